// File: rtl/tinyqv_instr_prefetch.sv
// tinyqv_instr_prefetch
// Instruction prefetch buffer between the TinyQV decoder and the memory
// controller's instruction-fetch port. Owns the fetch PC, issues fetch
// restarts (after reset, jumps, pre-emption and overflow), throttles fetch
// with a stall, and buffers returned halfwords in a circular FIFO.
//
// Ports:
//   clk, rst               clock / asynchronous active-high reset
//   cpu_jump, cpu_jump_addr flush buffer and redirect fetch (addr[23:1])
//   cpu_consume            halfwords taken by the decoder (0..2, 3 -> 2)
//   buf_data               {entry[head+1], entry[head]}, invalid halves read 0
//   buf_count              valid halfwords, 0..DEPTH
//   cpu_pc                 address [23:1] of entry[head]
//   instr_addr             fetch address [23:1] to memory controller
//   instr_fetch_restart    request a fetch start at instr_addr
//   instr_fetch_stall      buffer nearly full, hold fetch
//   instr_fetch_started    memory controller began fetching
//   instr_fetch_stopped    memory controller ended the fetch
//   instr_data, instr_ready returned halfword and its valid strobe
module tinyqv_instr_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [22:0] RESET_ADDR = '0,
  localparam int unsigned CW        = $clog2(DEPTH + 1),
  localparam int unsigned PW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_jump,
  input  logic [22:0]   cpu_jump_addr,
  input  logic [1:0]    cpu_consume,
  output logic [31:0]   buf_data,
  output logic [CW-1:0] buf_count,
  output logic [22:0]   cpu_pc,
  output logic [22:0]   instr_addr,
  output logic          instr_fetch_restart,
  output logic          instr_fetch_stall,
  input  logic          instr_fetch_started,
  input  logic          instr_fetch_stopped,
  input  logic [15:0]   instr_data,
  input  logic          instr_ready
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1C = CW'(DEPTH - 1);

  typedef enum logic {RESTART, FETCH} state_t;

  state_t        state_q;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [22:0]   pc_q, addr_q;
  logic [15:0]   mem_q [DEPTH];

  logic [1:0]    consume_req;
  logic [CW-1:0] consume_eff;
  logic [CW-1:0] count_d;
  logic          space, accept, overflow;
  logic [PW-1:0] head_p1;

  always_comb begin
    consume_req = (cpu_consume == 2'd3) ? 2'd2 : cpu_consume;
    consume_eff = (CW'(consume_req) > count_q) ? count_q : CW'(consume_req);
    // A full buffer still accepts when the decoder frees a slot this cycle.
    space       = (count_q < DEPTH_C) || (cpu_consume != 2'd0);
    accept      = !cpu_jump && (state_q == FETCH) && instr_ready && space;
    overflow    = !cpu_jump && (state_q == FETCH) && instr_ready && !space;
    count_d     = count_q - consume_eff + CW'(accept);
    head_p1     = head_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESTART;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
    end else if (cpu_jump) begin
      state_q <= RESTART;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= cpu_jump_addr;
      addr_q  <= cpu_jump_addr;
    end else begin
      if (accept) begin
        tail_q <= tail_q + PW'(1);
        addr_q <= addr_q + 23'd1;
      end
      head_q  <= head_q + PW'(consume_eff);
      pc_q    <= pc_q + 23'(consume_eff);
      count_q <= count_d;
      // A dropped halfword forces a restart so its address is refetched.
      if (instr_fetch_stopped || overflow)
        state_q <= RESTART;
      else if (state_q == RESTART && instr_fetch_started)
        state_q <= FETCH;
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (accept)
      mem_q[tail_q] <= instr_data;
  end

  always_comb begin
    buf_data[15:0]      = (count_q >= CW'(1)) ? mem_q[head_q]  : '0;
    buf_data[31:16]     = (count_q >= CW'(2)) ? mem_q[head_p1] : '0;
    buf_count           = count_q;
    cpu_pc              = pc_q;
    instr_addr          = addr_q;
    instr_fetch_restart = (state_q == RESTART);
    instr_fetch_stall   = (state_q == FETCH) && (count_q >= DEPTH_M1C);
  end

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
module tb_tinyqv_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_jump;
  logic [22:0] cpu_jump_addr;
  logic [1:0]  cpu_consume;
  logic [31:0] buf_data;
  logic [2:0]  buf_count;
  logic [22:0] cpu_pc;
  logic [22:0] instr_addr;
  logic        instr_fetch_restart;
  logic        instr_fetch_stall;
  logic        instr_fetch_started;
  logic        instr_fetch_stopped;
  logic [15:0] instr_data;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  tinyqv_instr_prefetch #(.DEPTH(4), .RESET_ADDR(23'h0)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cpu_jump            (cpu_jump),
    .cpu_jump_addr       (cpu_jump_addr),
    .cpu_consume         (cpu_consume),
    .buf_data            (buf_data),
    .buf_count           (buf_count),
    .cpu_pc              (cpu_pc),
    .instr_addr          (instr_addr),
    .instr_fetch_restart (instr_fetch_restart),
    .instr_fetch_stall   (instr_fetch_stall),
    .instr_fetch_started (instr_fetch_started),
    .instr_fetch_stopped (instr_fetch_stopped),
    .instr_data          (instr_data),
    .instr_ready         (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_jump = 0; cpu_consume = 0; instr_fetch_started = 0;
    instr_fetch_stopped = 0; instr_ready = 0; instr_data = 16'h0;
  endtask

  initial begin
    rst = 1; cpu_jump_addr = 23'h0; idle();
    #2;
    check("rst_restart", 32'(instr_fetch_restart), 32'h1);
    check("rst_addr",    32'(instr_addr), 32'h0);
    check("rst_pc",      32'(cpu_pc), 32'h0);
    check("rst_count",   32'(buf_count), 32'h0);
    check("rst_data",    buf_data, 32'h0);
    check("rst_stall",   32'(instr_fetch_stall), 32'h0);
    #1 rst = 0;

    // Start fetch and fill three halfwords
    instr_fetch_started = 1; tick(); idle();
    check("start_restart", 32'(instr_fetch_restart), 32'h0);
    instr_ready = 1; instr_data = 16'h1111; tick();
    check("fill1_count", 32'(buf_count), 32'h1);
    check("fill1_data",  buf_data, 32'h0000_1111);
    check("fill1_stall", 32'(instr_fetch_stall), 32'h0);
    instr_data = 16'h2222; tick();
    instr_data = 16'h3333; tick(); idle();
    check("fill3_count", 32'(buf_count), 32'h3);
    check("fill3_data",  buf_data, 32'h2222_1111);
    check("fill3_addr",  32'(instr_addr), 32'h3);
    check("fill3_stall", 32'(instr_fetch_stall), 32'h1);

    // Consume 2 with simultaneous arrival
    cpu_consume = 2; instr_ready = 1; instr_data = 16'h4444; tick(); idle();
    check("cons_count", 32'(buf_count), 32'h2);
    check("cons_data",  buf_data, 32'h4444_3333);
    check("cons_pc",    32'(cpu_pc), 32'h2);
    check("cons_addr",  32'(instr_addr), 32'h4);
    check("cons_stall", 32'(instr_fetch_stall), 32'h0);

    // Jump with ready high: data discarded
    cpu_jump = 1; cpu_jump_addr = 23'h100; instr_ready = 1; instr_data = 16'hDEAD;
    cpu_consume = 1; tick(); idle();
    check("jmp_count",   32'(buf_count), 32'h0);
    check("jmp_data",    buf_data, 32'h0);
    check("jmp_pc",      32'(cpu_pc), 32'h100);
    check("jmp_addr",    32'(instr_addr), 32'h100);
    check("jmp_restart", 32'(instr_fetch_restart), 32'h1);
    check("jmp_stall",   32'(instr_fetch_stall), 32'h0);

    // Pre-emption at 0x10
    cpu_jump = 1; cpu_jump_addr = 23'h10; tick(); idle();
    instr_fetch_started = 1; tick(); idle();
    check("pre_fetch", 32'(instr_fetch_restart), 32'h0);
    instr_fetch_stopped = 1; tick(); idle();
    check("pre_restart", 32'(instr_fetch_restart), 32'h1);
    check("pre_addr",    32'(instr_addr), 32'h10);
    instr_ready = 1; instr_data = 16'hBEEF; tick(); idle();
    check("pre_ignored_count", 32'(buf_count), 32'h0);
    check("pre_ignored_addr",  32'(instr_addr), 32'h10);
    instr_fetch_started = 1; tick(); idle();
    check("pre_resume", 32'(instr_fetch_restart), 32'h0);
    // Last halfword coincident with stop is still accepted
    instr_fetch_stopped = 1; instr_ready = 1; instr_data = 16'hAAAA; tick(); idle();
    check("stopacc_count",   32'(buf_count), 32'h1);
    check("stopacc_data",    buf_data, 32'h0000_AAAA);
    check("stopacc_addr",    32'(instr_addr), 32'h11);
    check("stopacc_restart", 32'(instr_fetch_restart), 32'h1);

    // Overflow: fill 4 from 0x1C
    cpu_jump = 1; cpu_jump_addr = 23'h1C; tick(); idle();
    instr_fetch_started = 1; tick(); idle();
    instr_ready = 1;
    instr_data = 16'hA0A0; tick();
    instr_data = 16'hA1A1; tick();
    instr_data = 16'hA2A2; tick();
    instr_data = 16'hA3A3; tick(); idle();
    check("full_count", 32'(buf_count), 32'h4);
    check("full_addr",  32'(instr_addr), 32'h20);
    check("full_stall", 32'(instr_fetch_stall), 32'h1);
    instr_ready = 1; instr_data = 16'h5555; tick(); idle();
    check("ovf_count",   32'(buf_count), 32'h4);
    check("ovf_addr",    32'(instr_addr), 32'h20);
    check("ovf_restart", 32'(instr_fetch_restart), 32'h1);
    check("ovf_stall",   32'(instr_fetch_stall), 32'h0);
    instr_fetch_started = 1; tick(); idle();
    check("ovf_resume", 32'(instr_fetch_restart), 32'h0);
    cpu_consume = 1; instr_ready = 1; instr_data = 16'h5555; tick(); idle();
    check("refetch_count", 32'(buf_count), 32'h4);
    check("refetch_addr",  32'(instr_addr), 32'h21);
    check("refetch_pc",    32'(cpu_pc), 32'h1D);
    check("refetch_data",  buf_data, 32'hA2A2_A1A1);
    cpu_consume = 2; tick(); idle();
    check("drain_count", 32'(buf_count), 32'h2);
    check("drain_data",  buf_data, 32'h5555_A3A3);
    check("drain_pc",    32'(cpu_pc), 32'h1F);
    cpu_consume = 3; tick(); idle();
    check("cons3_count", 32'(buf_count), 32'h0);
    check("cons3_pc",    32'(cpu_pc), 32'h21);
    check("cons3_data",  buf_data, 32'h0);
    cpu_consume = 2; tick(); idle();
    check("empty_cons_count", 32'(buf_count), 32'h0);
    check("empty_cons_pc",    32'(cpu_pc), 32'h21);

    // Address wrap
    cpu_jump = 1; cpu_jump_addr = 23'h7FFFFF; tick(); idle();
    instr_fetch_started = 1; tick(); idle();
    instr_ready = 1; instr_data = 16'h0101; tick();
    instr_data = 16'h0202; tick(); idle();
    check("wrap_addr",  32'(instr_addr), 32'h1);
    check("wrap_count", 32'(buf_count), 32'h2);
    check("wrap_data",  buf_data, 32'h0202_0101);
    cpu_consume = 2; tick(); idle();
    check("wrap_pc",       32'(cpu_pc), 32'h1);
    check("wrap_cons_cnt", 32'(buf_count), 32'h0);

    // Asynchronous reset mid-operation
    instr_ready = 1; instr_data = 16'h7777; tick(); idle();
    #2 rst = 1; #1;
    check("arst_count",   32'(buf_count), 32'h0);
    check("arst_addr",    32'(instr_addr), 32'h0);
    check("arst_pc",      32'(cpu_pc), 32'h0);
    check("arst_restart", 32'(instr_fetch_restart), 32'h1);
    check("arst_data",    buf_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyqv_instr_prefetch.md
# tinyqv_instr_prefetch

Instruction prefetch buffer between the TinyQV decoder and the memory controller's instruction-fetch port. It owns the fetch program counter and drives fetch restarts, including re-issuing a fetch after the memory controller pre-empts it for a data transaction. It also throttles fetch with a stall, and buffers returned 16-bit halfwords in a small circular FIFO. The decoder sees the two oldest halfwords and consumes 0, 1 or 2 per cycle.

## Interface
- DEPTH, 4: buffer depth in halfwords. Power of two, at least 2.
- RESET_ADDR, 23'h0: fetch address (halfword units, addr[23:1]) used after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_jump  in  1  one-cycle pulse: flush the buffer and redirect fetch.
- cpu_jump_addr  in  23  jump target [23:1].
- cpu_consume  in  2  halfwords removed this cycle (0, 1 or 2; 3 treated as 2).
- buf_data  out  32  {entry[head+1], entry[head]}; a half that is not valid reads as 0.
- buf_count  out  3  valid halfwords, 0..DEPTH.
- cpu_pc  out  23  address [23:1] of entry[head].
- instr_addr  out  23  fetch address [23:1] presented to the memory controller.
- instr_fetch_restart  out  1  request a fetch start at instr_addr.
- instr_fetch_stall  out  1  buffer nearly full; hold fetch.
- instr_fetch_started  in  1  pulse: memory controller began the fetch.
- instr_fetch_stopped  in  1  pulse: memory controller ended the fetch (pre-emption or restart).
- instr_data  in  16  returned halfword.
- instr_ready  in  1  instr_data is valid this cycle.

## Operation
- State machine with two states:
  - RESTART: instr_fetch_restart=1. All instr_ready pulses are ignored. Moves to FETCH on instr_fetch_started.
  - FETCH: instr_ready pulses are accepted. Moves to RESTART on instr_fetch_stopped.
- Event priority, highest first: rst > cpu_jump > instr_fetch_stopped > instr_fetch_started.
- cpu_jump, in any state:
  - Next cycle: buf_count=0, head and tail pointers cleared, cpu_pc=instr_addr=cpu_jump_addr, state=RESTART.
  - cpu_consume and instr_ready in the jump cycle are ignored.
- Accepted halfword (FETCH, instr_ready=1, space available):
  - Written at the tail.
  - instr_addr increments by 1, wrapping modulo 2^23.
- Space available means buf_count < DEPTH, or cpu_consume > 0 in the same cycle.
- Overflow (FETCH, instr_ready=1, buf_count==DEPTH, cpu_consume==0):
  - The halfword is dropped and instr_addr is not advanced.
  - Next cycle the state is RESTART, so the dropped address is refetched. No data is lost.
- Consume:
  - Effective consume = min(cpu_consume, buf_count) after mapping 3 to 2.
  - Head advances by the effective consume; cpu_pc increments by the same amount, modulo 2^23.
- Count update: buf_count_next = buf_count - consume_eff + accepted. Arrival and consume in the same cycle are both honoured.
- instr_fetch_stall = (buf_count >= DEPTH-1) && state==FETCH. This is a registered-count comparison; it combinationally depends only on state and count.
- After instr_fetch_stopped, the restart address is the current instr_addr. This is the first halfword not yet accepted.
- Buffer pointers are log2(DEPTH) bits and wrap naturally. The count is kept separately so full and empty are unambiguous.

## Timing
- Reset values: state=RESTART, instr_fetch_restart=1, instr_addr=cpu_pc=RESET_ADDR, buf_count=0, buf_data=0, instr_fetch_stall=0.
- Halfword accepted in cycle N:
  - buf_count and buf_data reflect it in cycle N+1.
  - instr_addr is updated in N+1.
- cpu_jump in cycle N: instr_fetch_restart=1 and the new instr_addr from N+1. instr_addr is held constant for the whole time restart is high.
- instr_fetch_started in cycle N: restart=0 in N+1. instr_ready is accepted from N+1 onward.
- instr_fetch_stopped in cycle N: restart=1 in N+1.
- instr_ready coincident with instr_fetch_stopped (last halfword before pre-emption) is accepted; FETCH is still the current state.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous). Partially accepted data is discarded.
- Outputs buf_data, buf_count, cpu_pc and instr_addr are registered or register-decoded only. They have no combinational path from the instr_* inputs.

## Test plan
- Reset release with RESET_ADDR=0:
  - instr_fetch_restart=1, instr_addr=0 before any input.
  - Pulse started, then three instr_ready with data 0x1111, 0x2222, 0x3333.
  - Expect buf_count=3, buf_data=0x22221111, instr_addr=3, instr_fetch_stall=1.
- From count 3, consume=2 and instr_ready 0x4444 in the same cycle.
  - Expect count=2, buf_data=0x44443333, cpu_pc=2, instr_addr=4, stall=0.
- cpu_jump with cpu_jump_addr=0x000100 while FETCH with count 2 and instr_ready high.
  - Expect next cycle count=0, buf_data=0, cpu_pc=instr_addr=0x100, restart=1.
  - The ready-cycle data is discarded.
- Pre-emption: in FETCH with instr_addr=0x10, pulse instr_fetch_stopped.
  - Expect restart=1 with instr_addr=0x10 next cycle.
  - instr_ready while in RESTART is ignored (count unchanged).
  - Started returns the block to FETCH.
- Overflow: count=4 (DEPTH=4), consume=0, instr_ready 0x5555 at instr_addr=0x20.
  - Expect count stays 4, instr_addr=0x20, restart=1 next cycle.
  - After started, 0x5555 refetched is accepted once consume frees space.
- Wrap: jump to 0x7FFFFF, started, two readys.
  - Expect instr_addr=0x000001.
  - Consume 2 gives cpu_pc=0x000001.
